vdp_host_master: RTL
====================

# vdp_host_master

Bus-master side of the video controller's host port. Accepts byte-level commands from the CPU-side fabric over a valid/ready handshake and generates the chip-select and write-strobe cycles that the video controller expects. Supported commands: address load, single data write, repeated fill and control-register write. Also synchronizes the controller's wait and interrupt lines back into the system clock domain.

## Interface
Parameters:
- SETUP, 1, clocks with hcs_n low, ha/hd driven, hwr_n high before the strobe (min 1)
- PULSE, 3, minimum clocks with hwr_n low (min 3)
- HOLD, 1, clocks with hwr_n high, hcs_n low and hd held after the strobe (min 1)

Ports (one clock, `clock`; reset `reset` is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  async active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when valid&ready
- cmd_op  in  2  00 SETADDR, 01 WRITE, 10 FILL, 11 CTRL
- cmd_addr  in  16  address for SETADDR
- cmd_data  in  8  data byte for WRITE/FILL/CTRL
- cmd_len  in  8  FILL count minus one
- busy  out  1  command in progress (= !cmd_ready)
- shadow_addr  out  16  block's copy of the controller's auto-increment pointer
- irq  out  1  synchronized, active-high copy of hint_n
- hcs_n  out  1  controller chip select
- hwr_n  out  1  write strobe; the controller latches on its rising edge
- hrd_n  out  1  read strobe, held high (write-only master)
- ha  out  2  controller register select
- hd  inout  8  data bus, driven only while hcs_n low
- hwait_n  in  1  controller wait request, async
- hint_n  in  1  controller interrupt, async

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: cmd_ready=1, hcs_n=1, hwr_n=1, hd released. On accept, the command is latched and the FSM goes to SETUP.
- Bus cycle sequence per command:
  - SETADDR: ha=00 with addr[7:0], then ha=01 with addr[15:8]. shadow_addr<=cmd_addr on accept.
  - WRITE: one cycle, ha=10, cmd_data.
  - FILL: cmd_len+1 cycles (0→1 byte, 255→256 bytes), ha=10, cmd_data.
  - CTRL: one cycle, ha=11, cmd_data. shadow_addr unchanged.
- SETUP counts SETUP clocks, then STROBE. STROBE counts PULSE clocks, then HOLD. HOLD counts HOLD clocks, then goes to SETUP if another bus cycle remains, else IDLE.
- hcs_n stays low continuously from the first SETUP to the last HOLD of a command. ha/hd change only on SETUP entry.
- Each completed ha=10 HOLD increments shadow_addr, 16-bit wrap FFFF→0000, matching the controller's pointer.
- Wait: hwait_n passes through a 2-flop synchronizer. If the synchronized value is 0 in the last PULSE clock, STROBE extends, unbounded, until it reads 1.
- irq = ~(2-flop synchronized hint_n).
- cmd_valid while busy is ignored; there is no queueing.

## Timing
- Reset values: hcs_n=1, hwr_n=1, hrd_n=1, ha=00, hd=Z, cmd_ready=1, busy=0, shadow_addr=0000, irq=0. Both synchronizers reset to 1.
- Accept at edge T0 → hcs_n low from T0+1. With defaults, one bus cycle = 5 clocks: S, P, P, P, H.
- WRITE: hcs_n low for 5 clocks; cmd_ready high 6 clocks after accept.
- SETADDR: 10 clocks. FILL n bytes: 5n clocks.
- Wait honoured only if asserted ≥2 clocks before the last PULSE clock; the slave must assert within PULSE-2 clocks of hwr_n falling.
- Reset mid-operation: all outputs return to reset values asynchronously. A reset during STROBE produces a hwr_n rising edge that the controller treats as a write. This is accepted; the system resets both blocks together.

## Structure
- Package vdp_host_pkg holds:
  - op codes OP_SETADDR/OP_WRITE/OP_FILL/OP_CTRL
  - register selects HA_ADL=00, HA_ADH=01, HA_DATA=10, HA_CTRL=11
  - FSM state encoding
- Sub-module sync2 (2-flop synchronizer with reset value parameter) is instantiated twice, for hwait_n and hint_n.

## Test plan
- Reset, then WRITE data=5A: hcs_n low 5 clocks; hwr_n low clocks 2–4; ha=10; hd=5A stable through the hwr_n rise; shadow 0000→0001; cmd_ready back 6 clocks after accept.
- SETADDR 12F0 then FILL len=2 data=33: ha sequence 00(F0), 01(12), 10×3; shadow ends 12F3; FILL lasts 15 clocks.
- SETADDR FFFF then WRITE: shadow wraps to 0000.
- hwait_n held low 6 clocks starting 1 clock after hwr_n falls: STROBE extends; hwr_n rises 2–3 clocks after hwait_n returns high; no ha/hd change during the stretch.
- cmd_valid held high through a FILL: no second accept until IDLE. CTRL data=80: ha=11, shadow unchanged.
- Assert reset in mid-STROBE: hwr_n/hcs_n go high immediately, hd=Z, cmd_ready=1. Toggling hint_n low → irq=1 two clocks later.

Source files
------------

// File: rtl/vdp_host_pkg.sv
// Shared definitions for the video controller host-port master: command
// op codes, controller register selects and the bus-cycle FSM encoding.
package vdp_host_pkg;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_FILL    = 2'b10;
  localparam logic [1:0] OP_CTRL    = 2'b11;

  localparam logic [1:0] HA_ADL  = 2'b00;
  localparam logic [1:0] HA_ADH  = 2'b01;
  localparam logic [1:0] HA_DATA = 2'b10;
  localparam logic [1:0] HA_CTRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_STROBE = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

  // Register select used by the first bus cycle of a command.
  function automatic logic [1:0] first_ha(input logic [1:0] op);
    logic [1:0] sel;
    sel = HA_DATA;
    if (op == OP_SETADDR) sel = HA_ADL;
    else if (op == OP_CTRL) sel = HA_CTRL;
    return sel;
  endfunction

endpackage

// File: rtl/vdp_host_if.sv
// Command handshake between the CPU-side fabric (master) and the host-port
// master block (slave).
interface vdp_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/vdp_host_sync2.sv
// Two-flop synchronizer for asynchronous controller status lines; both
// flops reset to RST_VAL so the output is quiet straight out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vdp_host_master.sv
// Host-port bus master: turns accepted commands into chip-select / write-strobe
// cycles towards the video controller and tracks its auto-increment pointer.
module vdp_host_master
  import vdp_host_pkg::*;
#(
  parameter int SETUP = 1,
  parameter int PULSE = 3,
  parameter int HOLD  = 1
) (
  input  logic        clock,
  input  logic        reset,
  vdp_host_if.slave   cmd,
  output logic        busy,
  output logic [15:0] shadow_addr,
  output logic        irq,
  output logic        hcs_n,
  output logic        hwr_n,
  output logic        hrd_n,
  output logic [1:0]  ha,
  inout  wire  [7:0]  hd,
  input  logic        hwait_n,
  input  logic        hint_n
);

  state_e      state;
  logic [7:0]  cnt;
  logic [7:0]  rem;
  logic [7:0]  addr_hi;
  logic [7:0]  hd_q;
  logic        ready_q;
  logic        wait_s;
  logic        hint_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_wait (
    .clock (clock),
    .reset (reset),
    .d     (hwait_n),
    .q     (wait_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_int (
    .clock (clock),
    .reset (reset),
    .d     (hint_n),
    .q     (hint_s)
  );

  // The accept clock only latches the command, so SETUP is loaded one longer
  // and hcs_n drops on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      rem         <= 8'd0;
      addr_hi     <= 8'd0;
      hd_q        <= 8'd0;
      ha          <= HA_ADL;
      hcs_n       <= 1'b1;
      hwr_n       <= 1'b1;
      ready_q     <= 1'b1;
      shadow_addr <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            ready_q <= 1'b0;
            state   <= ST_SETUP;
            cnt     <= 8'(SETUP);
            ha      <= first_ha(cmd.cmd_op);
            case (cmd.cmd_op)
              OP_SETADDR: begin
                hd_q        <= cmd.cmd_addr[7:0];
                addr_hi     <= cmd.cmd_addr[15:8];
                rem         <= 8'd1;
                shadow_addr <= cmd.cmd_addr;
              end
              OP_FILL: begin
                hd_q <= cmd.cmd_data;
                rem  <= cmd.cmd_len;
              end
              default: begin
                hd_q <= cmd.cmd_data;
                rem  <= 8'd0;
              end
            endcase
          end
        end
        ST_SETUP: begin
          hcs_n <= 1'b0;
          if (cnt == 8'd0) begin
            state <= ST_STROBE;
            hwr_n <= 1'b0;
            cnt   <= 8'(PULSE - 1);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (wait_s) begin
            state <= ST_HOLD;
            hwr_n <= 1'b1;
            cnt   <= 8'(HOLD - 1);
          end
        end
        ST_HOLD: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (ha == HA_DATA) shadow_addr <= shadow_addr + 16'd1;
            if (rem != 8'd0) begin
              rem   <= rem - 8'd1;
              state <= ST_SETUP;
              cnt   <= 8'(SETUP - 1);
              if (ha == HA_ADL) begin
                ha   <= HA_ADH;
                hd_q <= addr_hi;
              end
            end else begin
              state   <= ST_IDLE;
              hcs_n   <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = ~ready_q;
  assign irq           = ~hint_s;
  assign hrd_n         = 1'b1;
  assign hd            = hcs_n ? 8'bzzzz_zzzz : hd_q;

endmodule
